// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared Q-format constants, fp32 fields, FSM encoding and CORDIC tables
package cordic_pkg;

  localparam int FRAC_Q230 = 30;
  localparam int FRAC_Q329 = 29;

  localparam logic [31:0] PI_Q29      = 32'h6487ED51;
  localparam logic [31:0] HALF_PI_Q29 = 32'h3243F6A9;
  localparam int          LAT         = 3;

  localparam int FP_SIGN_BIT = 31;
  localparam int FP_EXP_LSB  = 23;
  localparam int FP_EXP_W    = 8;
  localparam int FP_MAN_W    = 23;

  localparam int EXP_BIAS   = 127;
  localparam int EXP_MIN_NZ = 98;
  localparam int EXP_MAX    = 128;

  // Exponent at which mant24 already sits at Q3.29 scale (no shift needed).
  localparam int SHIFT_ZERO_EXP = EXP_BIAS - (FRAC_Q329 - FP_MAN_W);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_SHIFT,
    ST_FOLD
  } prep_state_t;

  localparam logic [31:0] CORDIC_GAIN_Q230 = 32'h26DD3B6A;
  localparam int          ATAN_N           = 8;

  // atan(2^-i) in Q2.30, truncated.
  function automatic logic [31:0] atan_lut(input logic [2:0] i);
    case (i)
      3'd0:    atan_lut = 32'h3243F6A8;
      3'd1:    atan_lut = 32'h1DAC6705;
      3'd2:    atan_lut = 32'h0FADBAFC;
      3'd3:    atan_lut = 32'h07F56EA6;
      3'd4:    atan_lut = 32'h03FEAB77;
      3'd5:    atan_lut = 32'h01FFD55B;
      3'd6:    atan_lut = 32'h00FFFAAA;
      default: atan_lut = 32'h007FFF55;
    endcase
  endfunction

endpackage

// File: rtl/fp32_unpack_shift.sv
// rtl/fp32_unpack_shift.sv - barrel-shifts a 24-bit fp32 significand to unsigned Q3.29
module fp32_unpack_shift
  import cordic_pkg::*;
(
  input  logic [23:0] mant24,
  input  logic [7:0]  exp_field,
  output logic [31:0] mag,
  output logic        underflow,
  output logic        overflow
);

  logic [7:0] lsh;
  logic [7:0] rsh;

  always_comb begin
    lsh       = exp_field - 8'(SHIFT_ZERO_EXP);
    rsh       = 8'(SHIFT_ZERO_EXP) - exp_field;
    underflow = exp_field < 8'(EXP_MIN_NZ);
    overflow  = exp_field > 8'(EXP_MAX);
    if (exp_field >= 8'(SHIFT_ZERO_EXP)) begin
      mag = {8'd0, mant24} << lsh;
    end else begin
      mag = {8'd0, mant24} >> rsh;
    end
  end

endmodule

// File: rtl/cordic_cos_prep.sv
// rtl/cordic_cos_prep.sv - fp32 angle to folded Q2.30 CORDIC z-input with cosine negate flag
module cordic_cos_prep
  import cordic_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  output logic [31:0] result,
  output logic        neg,
  output logic        range_err,
  output logic        busy,
  output logic        done
);

  prep_state_t state_q;
  prep_state_t state_d;

  logic [7:0]  exp_q;
  logic [22:0] frac_q;
  logic [23:0] mant24_q;
  logic        err_q;
  logic [31:0] mag_q;

  logic [31:0] shift_mag;
  logic        shift_unf;
  logic        shift_ovf;

  logic [31:0] fold_result;
  logic        fold_neg;
  logic        fold_err;

  // Cosine is even, so the sign bit never reaches the datapath.
  logic unused_sign;
  assign unused_sign = dataa[FP_SIGN_BIT];

  assign busy = (state_q != ST_IDLE);

  fp32_unpack_shift u_shift (
    .mant24    (mant24_q),
    .exp_field (exp_q),
    .mag       (shift_mag),
    .underflow (shift_unf),
    .overflow  (shift_ovf)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_UNPACK;
      ST_UNPACK: state_d = ST_SHIFT;
      ST_SHIFT:  state_d = ST_FOLD;
      ST_FOLD:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fold_result = '0;
    fold_neg    = 1'b0;
    fold_err    = err_q;
    if (!err_q) begin
      if (mag_q > PI_Q29) begin
        fold_err = 1'b1;
      end else if (mag_q > HALF_PI_Q29) begin
        fold_result = (PI_Q29 - mag_q) << 1;
        fold_neg    = 1'b1;
      end else begin
        fold_result = mag_q << 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      exp_q     <= '0;
      frac_q    <= '0;
      mant24_q  <= '0;
      err_q     <= 1'b0;
      mag_q     <= '0;
      result    <= '0;
      neg       <= 1'b0;
      range_err <= 1'b0;
      done      <= 1'b0;
    end else if (clk_en) begin
      state_q <= state_d;
      done    <= (state_q == ST_FOLD);
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            exp_q  <= dataa[FP_EXP_LSB +: FP_EXP_W];
            frac_q <= dataa[FP_MAN_W-1:0];
          end
        end
        ST_UNPACK: begin
          mant24_q <= {exp_q != 8'd0, frac_q};
          err_q    <= exp_q > 8'(EXP_MAX);
        end
        ST_SHIFT: begin
          mag_q <= (shift_unf || shift_ovf) ? '0 : shift_mag;
          err_q <= err_q | shift_ovf;
        end
        ST_FOLD: begin
          result    <= fold_result;
          neg       <= fold_neg;
          range_err <= fold_err;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_cos_prep.sv
// tb/tb_cordic_cos_prep.sv - directed-vector bench for cordic_cos_prep
module tb_cordic_cos_prep;

  logic        clk;
  logic        reset;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic [31:0] result;
  logic        neg;
  logic        range_err;
  logic        busy;
  logic        done;

  int tests;
  int fails;

  cordic_cos_prep dut (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .start     (start),
    .dataa     (dataa),
    .result    (result),
    .neg       (neg),
    .range_err (range_err),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {angle, result, neg, range_err}
  localparam int NV = 21;
  logic [65:0] vecs [NV] = '{
    {32'h3F800000, 32'h40000000, 1'b0, 1'b0},
    {32'hBF800000, 32'h40000000, 1'b0, 1'b0},
    {32'h00000000, 32'h00000000, 1'b0, 1'b0},
    {32'h40000000, 32'h490FDAA2, 1'b1, 1'b0},
    {32'hC0000000, 32'h490FDAA2, 1'b1, 1'b0},
    {32'h40600000, 32'h00000000, 1'b0, 1'b1},
    {32'h7FC00000, 32'h00000000, 1'b0, 1'b1},
    {32'h7F800000, 32'h00000000, 1'b0, 1'b1},
    {32'h2B800000, 32'h00000000, 1'b0, 1'b0},
    {32'h00000001, 32'h00000000, 1'b0, 1'b0},
    {32'h3F000000, 32'h20000000, 1'b0, 1'b0},
    {32'h3FC00000, 32'h60000000, 1'b0, 1'b0},
    {32'h3A800000, 32'h00100000, 1'b0, 1'b0},
    {32'h3FC90FDA, 32'h6487ED00, 1'b0, 1'b0},
    {32'h3FC90FDB, 32'h6487ED22, 1'b1, 1'b0},
    {32'h40490FDA, 32'h000000A2, 1'b1, 1'b0},
    {32'h40490FDB, 32'h00000000, 1'b0, 1'b1},
    {32'h40800000, 32'h00000000, 1'b0, 1'b1},
    {32'h31000000, 32'h00000002, 1'b0, 1'b0},
    {32'h30800000, 32'h00000000, 1'b0, 1'b0},
    {32'h3F800000, 32'h40000000, 1'b0, 1'b0}
  };

  task automatic run_op(input logic [31:0] a, output int lat);
    @(negedge clk);
    start = 1'b1;
    dataa = a;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    clk_en = 1'b1;
    start  = 1'b0;
    dataa  = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({result, neg, range_err, busy, done} !== 36'd0) begin
      fails++;
      $display("FAIL reset_state: got %h want 0", {result, neg, range_err, busy, done});
    end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if ({busy, done} !== 2'b00) begin
      fails++;
      $display("FAIL idle_after_reset: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_vectors();
    int lat;
    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i][65:34], lat);
      tests++;
      if (lat !== 3) begin
        fails++;
        $display("FAIL latency[%0d]: got %0d want 3", i, lat);
      end
      tests++;
      if ({result, neg, range_err} !== vecs[i][33:0]) begin
        fails++;
        $display("FAIL vector[%0d] %h: got result=%h neg=%b err=%b want result=%h neg=%b err=%b",
                 i, vecs[i][65:34], result, neg, range_err,
                 vecs[i][33:2], vecs[i][1], vecs[i][0]);
      end
    end
  endtask

  task automatic test_start_held();
    int          done_cnt;
    logic [31:0] r_first;
    logic        busy_at4;
    done_cnt = 0;
    r_first  = '0;
    busy_at4 = 1'b0;
    @(negedge clk);
    start = 1'b1;
    dataa = 32'h40000000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      dataa = 32'h3F800000;
      if (done) done_cnt++;
      if (i == 3) r_first = result;
      if (i == 4) busy_at4 = busy;
    end
    start = 1'b0;
    tests++;
    if (done_cnt !== 1) begin
      fails++;
      $display("FAIL held_done_count: got %0d want 1", done_cnt);
    end
    tests++;
    if (r_first !== 32'h490FDAA2) begin
      fails++;
      $display("FAIL held_first_result: got %h want 490fdaa2", r_first);
    end
    tests++;
    if (busy_at4 !== 1'b1) begin
      fails++;
      $display("FAIL held_resample_busy: got %b want 1", busy_at4);
    end
    repeat (3) @(negedge clk);
    tests++;
    if ({done, result, neg} !== {1'b1, 32'h40000000, 1'b0}) begin
      fails++;
      $display("FAIL held_second_op: got done=%b result=%h neg=%b want 1 40000000 0", done, result, neg);
    end
  endtask

  task automatic test_stall();
    logic early;
    early = 1'b0;
    @(negedge clk);
    start = 1'b1;
    dataa = 32'h40000000;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    clk_en = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) early = 1'b1;
    end
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL stall_busy: got %b want 1", busy);
    end
    clk_en = 1'b1;
    @(negedge clk);
    if (done) early = 1'b1;
    @(negedge clk);
    tests++;
    if ({early, done} !== 2'b01) begin
      fails++;
      $display("FAIL stall_done_timing: got early=%b done=%b want 0 1", early, done);
    end
    tests++;
    if ({result, neg, range_err} !== {32'h490FDAA2, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL stall_values: got %h %b %b want 490fdaa2 1 0", result, neg, range_err);
    end
    clk_en = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL done_stretch: got %b want 1", done);
    end
    clk_en = 1'b1;
    @(negedge clk);
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL done_release: got %b want 0", done);
    end
  endtask

  task automatic test_reset_mid_op();
    logic saw_done;
    int   lat;
    saw_done = 1'b0;
    @(negedge clk);
    start = 1'b1;
    dataa = 32'h3F800000;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests++;
    if ({result, neg, range_err, busy, done} !== 36'd0) begin
      fails++;
      $display("FAIL reset_mid_op: got %h want 0", {result, neg, range_err, busy, done});
    end
    repeat (4) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    tests++;
    if (saw_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_no_done: got %b want 0", saw_done);
    end
    run_op(32'h3F000000, lat);
    tests++;
    if ({lat == 3, result} !== {1'b1, 32'h20000000}) begin
      fails++;
      $display("FAIL reset_recovery: got lat=%0d result=%h want 3 20000000", lat, result);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_vectors();
    test_start_held();
    test_stall();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cordic_cos_prep.md
Name: cordic_cos_prep

Overview:
- Upstream pre-processing stage for the CORDIC cosine core, built as a multi-cycle Nios II custom instruction.
- Accepts an IEEE-754 single-precision angle in radians and converts it to the signed Q2.30 angle format consumed by the CORDIC z-input (pi/4 = 0x3243F6A8 in Q2.30).
- Folds |x| into [0, pi/2] using cos(x) = cos(|x|) = -cos(pi - |x|), and emits a negate flag so the downstream stage can correct the sign of the CORDIC x output.

Parameters:
- PI_Q29, 32'h6487ED51, pi in unsigned Q3.29 (rounded).
- HALF_PI_Q29, 32'h3243F6A9, pi/2 in unsigned Q3.29 (rounded).
- LAT, 3, clk_en-qualified cycles from start sample to done. Fixed; not for override.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clk_en  in  1  global enable; when low, all state is frozen
- start  in  1  one-cycle request; dataa is valid while start is high
- dataa  in  32  fp32 angle in radians
- result  out  32  Q2.30 folded angle in [0, pi/2]
- neg  out  1  1 = downstream must negate the cosine
- range_err  out  1  input NaN/Inf or |x| > pi
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse

Behaviour:
- Clocking: one clock; reset is synchronous and active-high. reset has priority over clk_en.
- Reset values: result=0, neg=0, range_err=0, busy=0, done=0, state=IDLE.
- FSM states: IDLE -> UNPACK -> SHIFT -> FOLD -> IDLE. A transition is taken only on edges where clk_en=1.
- IDLE: when start=1, latch the sign s, exponent e and mantissa m from dataa, then go to UNPACK. Clear done.
- UNPACK:
  - mant24 = {e!=0, m}.
  - If e=255, set range_err.
  - If e=0 or e<98, the magnitude is zero (denormals flush to zero).
  - If e>=129 (|x|>=4), set range_err.
  - Otherwise, shift amount sh = e-121; positive means shift left, negative means shift right.
- SHIFT: mag (unsigned Q3.29) = mant24 << sh, or mant24 >> -sh. Shift in one cycle with a barrel shifter. Truncate toward zero. The sign s is discarded because cosine is even.
- FOLD:
  - If range_err: result=0, neg=0.
  - Else if mag > PI_Q29: range_err=1, result=0, neg=0.
  - Else if mag > HALF_PI_Q29: result=(PI_Q29-mag)<<1, neg=1.
  - Else: result=mag<<1, neg=0.
  - Assert done for one cycle on the edge that leaves FOLD.
- Latency: start sampled at edge N gives done=1 and valid result after edge N+3 (counting clk_en cycles only).
- Output hold: result, neg and range_err hold until the next accepted start.
- Boundary conditions:
  - start while busy: ignored, with no effect on the op in flight.
  - start coincident with done: not accepted until the FSM is back in IDLE, i.e. the next cycle.
  - clk_en low mid-op: state, outputs and the done pulse all stretch. done stays high until the next clk_en=1 edge.
  - reset mid-op: abort immediately to reset values. No done pulse.
  - mag == HALF_PI_Q29: no fold, neg=0.
  - mag == PI_Q29: fold to result=0, neg=1.

Decomposition:
- Package cordic_pkg holds:
  - PI_Q29, HALF_PI_Q29, and the Q-format widths/constants (FRAC_Q230=30, FRAC_Q329=29).
  - fp32 field positions, EXP_BIAS=127, EXP_MIN_NZ=98, EXP_MAX=128.
  - The FSM state encoding.
  - The CORDIC gain and angle LUT, also consumed by the CORDIC core.
- One natural sub-module: fp32_unpack_shift. It is combinational: takes mant24/e, returns mag Q3.29 plus underflow/overflow flags. It is instantiated in the SHIFT stage.

Test Plan:
- 0x3F800000 (1.0) -> after 3 cycles: done=1, result=0x40000000, neg=0, range_err=0.
- 0xBF800000 (-1.0) -> result=0x40000000, neg=0. Then 0x00000000 -> result=0, neg=0.
- 0x40000000 (2.0) -> result=0x490FDAA2, neg=1 (pi-2 folded).
- 0x40600000 (3.5), then 0x7FC00000 (NaN) -> each gives range_err=1, result=0, neg=0.
- 0x2B800000 (2^-40) -> result=0. Also: start held high for 5 cycles -> exactly one done pulse; the second op begins only when start is re-sampled in IDLE.
- Stall and reset:
  - Start 2.0 with clk_en low for 4 cycles in SHIFT -> done appears 4 cycles late with correct values.
  - reset asserted in FOLD -> next cycle all outputs 0, busy=0, no done.
